gate_array_pipe: RTL and testbench

- Parametrised successor to the single-bit two-input gates: a WIDTH-bit bitwise logic unit with eight selectable gate operations.
- Two-stage valid/ready pipeline with full throughput and backpressure.
- Running accumulator lets a stream of beats be folded through a chosen gate.
- Sits between a producer and consumer in the logic-chunks datapath examples and is the base block for wider gate benches.

---
 rtl/gate_pkg.sv | 17 +
 rtl/gate_array_pipe_if.sv | 41 ++++
 rtl/gate_op_unit.sv | 28 ++
 rtl/gate_array_pipe.sv | 100 ++++++++++
 tb/tb_gate_array_pipe.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_pkg.sv
// Shared types for the gate array datapath: op encoding and its width.
package gate_pkg;

    localparam int unsigned GATE_OP_W = 3;

    typedef enum logic [GATE_OP_W-1:0] {
        GATE_AND   = 3'd0,
        GATE_OR    = 3'd1,
        GATE_XOR   = 3'd2,
        GATE_NAND  = 3'd3,
        GATE_NOR   = 3'd4,
        GATE_XNOR  = 3'd5,
        GATE_ANDN  = 3'd6,
        GATE_PASSB = 3'd7
    } gate_op_t;

endpackage

// File: rtl/gate_array_pipe_if.sv
// Producer/consumer handshake bundle for gate_array_pipe.
// out_parity exists only when GATE_ARRAY_PIPE_PARITY_EN is defined.
interface gate_array_pipe_if
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [GATE_OP_W-1:0] in_op;
    logic                 in_acc;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [GATE_OP_W-1:0] out_op;
`ifdef GATE_ARRAY_PIPE_PARITY_EN
    logic                 out_parity;
`endif

    // Block side: consumes input beats, produces results
    modport slave (
        input  in_valid, in_op, in_acc, in_a, in_b, out_ready,
`ifdef GATE_ARRAY_PIPE_PARITY_EN
        output out_parity,
`endif
        output in_ready, out_valid, out_data, out_op
    );

    // Environment side: producer and consumer of the block
    modport master (
        output in_valid, in_op, in_acc, in_a, in_b, out_ready,
`ifdef GATE_ARRAY_PIPE_PARITY_EN
        input  out_parity,
`endif
        input  in_ready, out_valid, out_data, out_op
    );

endinterface

// File: rtl/gate_op_unit.sv
// Combinational WIDTH-bit bitwise gate selected by a gate_op_t.
module gate_op_unit
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  gate_op_t         i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result_c
);

    always_comb begin
        o_result_c = '0;
        case (i_op)
            GATE_AND:   o_result_c = i_a & i_b;
            GATE_OR:    o_result_c = i_a | i_b;
            GATE_XOR:   o_result_c = i_a ^ i_b;
            GATE_NAND:  o_result_c = ~(i_a & i_b);
            GATE_NOR:   o_result_c = ~(i_a | i_b);
            GATE_XNOR:  o_result_c = ~(i_a ^ i_b);
            GATE_ANDN:  o_result_c = i_a & ~i_b;
            GATE_PASSB: o_result_c = i_b;
            default:    o_result_c = '0;
        endcase
    end

endmodule

// File: rtl/gate_array_pipe.sv
// Two-stage valid/ready bitwise gate pipeline with a running accumulator.
// Define GATE_ARRAY_PIPE_PARITY_EN to add the registered out_parity output.
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    gate_array_pipe_if.slave   bus
);

    logic                 r_s1_valid;
    gate_op_t             r_s1_op;
    logic                 r_s1_acc;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_b;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [GATE_OP_W-1:0] r_out_op;
    logic [WIDTH-1:0]     r_acc;

    logic                 w_s2_load;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_op_a;
    logic [WIDTH-1:0]     w_result;

    // Stage 2 advances when s1 holds a beat and the output slot is free or draining
    assign w_s2_load  = r_s1_valid && (!r_out_valid || bus.out_ready);
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_op_a     = r_s1_acc ? r_acc : r_s1_a;

    gate_op_unit #(
        .WIDTH      (WIDTH)
    ) u_gate_op_unit (
        .i_op       (r_s1_op),
        .i_a        (w_op_a),
        .i_b        (r_s1_b),
        .o_result_c (w_result)
    );

    // Stage 1: capture the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= GATE_AND;
            r_s1_acc   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= gate_op_t'(bus.in_op);
            r_s1_acc   <= bus.in_acc;
            r_s1_a     <= bus.in_a;
            r_s1_b     <= bus.in_b;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: compute, update ACC and the output register in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_op    <= '0;
            r_acc       <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_op    <= GATE_OP_W'(r_s1_op);
            r_acc       <= w_result;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef GATE_ARRAY_PIPE_PARITY_EN
    logic r_out_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_parity <= 1'b0;
        end else if (w_s2_load) begin
            r_out_parity <= ^w_result;
        end
    end

    assign bus.out_parity = r_out_parity;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_op    = r_out_op;

endmodule

// File: tb/tb_gate_array_pipe.sv
// Self-checking bench for gate_array_pipe: directed scenarios plus a randomized
// stream checked against an in-order scoreboard model.
module tb_gate_array_pipe;
    import gate_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic [2:0]   op;
    } beat_t;

    beat_t        sb[$];
    logic [W-1:0] m_acc;

    always #5 clk = ~clk;

    gate_array_pipe_if #(.WIDTH(W)) bus ();

    gate_array_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [W-1:0] gate_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            3:       return ~(a & b);
            4:       return ~(a | b);
            5:       return ~(a ^ b);
            6:       return a & ~b;
            default: return b;
        endcase
    endfunction

    task automatic set_in(input logic v, input int op, input logic acc, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = v;
        bus.in_op    = 3'(op);
        bus.in_acc   = acc;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        set_in(1'b0, 0, 1'b0, '0, '0);
        #12;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        n_checks++; if (bus.out_op !== 3'd0) begin n_fail++; $display("FAIL reset_out_op: got %0d expected 0", bus.out_op); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_single_beat();
        bus.out_ready = 1'b1;
        set_in(1'b1, 0, 1'b0, 8'hF0, 8'h3C);
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        set_in(1'b0, 0, 1'b0, '0, '0);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", bus.out_valid); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h30) begin n_fail++; $display("FAIL single_data: got %h expected 30", bus.out_data); end
        n_checks++; if (bus.out_op !== 3'd0) begin n_fail++; $display("FAIL single_op: got %0d expected 0", bus.out_op); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_op_sweep();
        logic [W-1:0] exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA0, 8'h0F};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, i, 1'b0, 8'hA5, 8'h0F);
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready op%0d: got %b expected 1", i, bus.in_ready); end
            tick();
            if (i > 0) begin
                n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i-1] || bus.out_op !== 3'(i-1))
                    begin n_fail++; $display("FAIL sweep op%0d: got v=%b d=%h op=%0d expected v=1 d=%h op=%0d", i-1, bus.out_valid, bus.out_data, bus.out_op, exp[i-1], i-1); end
            end
        end
        set_in(1'b0, 0, 1'b0, '0, '0);
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[7] || bus.out_op !== 3'd7)
            begin n_fail++; $display("FAIL sweep op7: got v=%b d=%h op=%0d expected v=1 d=%h op=7", bus.out_valid, bus.out_data, bus.out_op, exp[7]); end
        tick();
    endtask

    task automatic test_accumulate();
        int           ops [4]  = '{1, 1, 2, 0};
        logic         accs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] bs [4]   = '{8'h02, 8'h04, 8'hFF, 8'h0F};
        logic [W-1:0] exp [4]  = '{8'h03, 8'h07, 8'hF8, 8'h08};
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) set_in(1'b1, ops[i], accs[i], (i == 0) ? 8'h01 : 8'($urandom), bs[i]);
            else       set_in(1'b0, 0, 1'b0, '0, '0);
            tick();
            if (i > 0) begin
                n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i-1])
                    begin n_fail++; $display("FAIL acc_chain step%0d: got v=%b d=%h expected v=1 d=%h", i-1, bus.out_valid, bus.out_data, exp[i-1]); end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, i, 1'b0, 8'hA5, 8'h0F);
            #1;
            if (bus.in_ready) accepted++;
            if (i < 2) tick();
        end
        n_checks++; if (accepted !== 2) begin n_fail++; $display("FAIL bp_accept_count: got %0d expected 2", accepted); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h05 || bus.in_ready !== 1'b0)
                begin n_fail++; $display("FAIL bp_stall cyc%0d: got v=%b d=%h rdy=%b expected v=1 d=05 rdy=0", c, bus.out_valid, bus.out_data, bus.in_ready); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        tick();
        set_in(1'b0, 0, 1'b0, '0, '0);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hAF) begin n_fail++; $display("FAIL bp_drain1: got v=%b d=%h expected v=1 d=AF", bus.out_valid, bus.out_data); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hAA) begin n_fail++; $display("FAIL bp_drain2: got v=%b d=%h expected v=1 d=AA", bus.out_valid, bus.out_data); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_empty: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        set_in(1'b1, 1, 1'b0, 8'h11, 8'h22);
        tick();
        set_in(1'b1, 0, 1'b0, 8'hFF, 8'hFF);
        tick();
        set_in(1'b0, 0, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_async: got v=%b d=%h expected v=0 d=00", bus.out_valid, bus.out_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", bus.in_ready); end
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stale cyc%0d: got %b expected 0", c, bus.out_valid); end
        end
        set_in(1'b1, 1, 1'b1, 8'($urandom), 8'h10);
        tick();
        set_in(1'b0, 0, 1'b0, '0, '0);
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10) begin n_fail++; $display("FAIL mid_reset_acc_clear: got v=%b d=%h expected v=1 d=10", bus.out_valid, bus.out_data); end
        tick();
    endtask

`ifdef GATE_ARRAY_PIPE_PARITY_EN
    task automatic test_parity();
        bus.out_ready = 1'b1;
        set_in(1'b1, 1, 1'b0, 8'h07, 8'h00);
        tick();
        set_in(1'b1, 2, 1'b0, 8'h03, 8'h00);
        tick();
        set_in(1'b0, 0, 1'b0, '0, '0);
        n_checks++; if (bus.out_data !== 8'h07 || bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_odd: got d=%h p=%b expected d=07 p=1", bus.out_data, bus.out_parity); end
        tick();
        n_checks++; if (bus.out_data !== 8'h03 || bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_even: got d=%h p=%b expected d=03 p=0", bus.out_data, bus.out_parity); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic         seeded = 1'b0;
        logic         pend = 1'b0;
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        logic [2:0]   prev_op = '0;
        int           p_op = 0;
        logic         p_acc = 1'b0;
        logic [W-1:0] p_a = '0, p_b = '0, a_val, res;
        beat_t        b;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pend && ($urandom_range(0, 9) < 7)) begin
                pend  = 1'b1;
                p_op  = int'($urandom_range(0, 7));
                p_acc = seeded ? 1'($urandom) : 1'b0;
                p_a   = 8'($urandom);
                p_b   = 8'($urandom);
            end
            set_in(pend, p_op, p_acc, p_a, p_b);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            #1;
            if (prev_stall) begin
                n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_op !== prev_op)
                    begin n_fail++; $display("FAIL rand_stall_hold cyc%0d: got v=%b d=%h op=%0d expected v=1 d=%h op=%0d", cyc, bus.out_valid, bus.out_data, bus.out_op, prev_data, prev_op); end
            end
            if (pend && bus.in_ready) begin
                a_val  = p_acc ? m_acc : p_a;
                res    = gate_ref(p_op, a_val, p_b);
                m_acc  = res;
                seeded = 1'b1;
                sb.push_back('{data: res, op: 3'(p_op)});
                pend   = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rand_unexpected cyc%0d: got d=%h expected no output", cyc, bus.out_data);
                end else begin
                    b = sb.pop_front();
                    if (bus.out_data !== b.data || bus.out_op !== b.op) begin
                        n_fail++; $display("FAIL rand_data cyc%0d: got d=%h op=%0d expected d=%h op=%0d", cyc, bus.out_data, bus.out_op, b.data, b.op);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_op    = bus.out_op;
            tick();
        end
        set_in(1'b0, 0, 1'b0, '0, '0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            #1;
            if (bus.out_valid) begin
                b = sb.pop_front();
                n_checks++; if (bus.out_data !== b.data || bus.out_op !== b.op)
                    begin n_fail++; $display("FAIL rand_drain: got d=%h op=%0d expected d=%h op=%0d", bus.out_data, bus.out_op, b.data, b.op); end
            end
            tick();
        end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_lost_beats: got %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        m_acc = '0;
        test_reset();
        test_single_beat();
        test_op_sweep();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
`ifdef GATE_ARRAY_PIPE_PARITY_EN
        test_parity();
`endif
        m_acc = 8'h00;
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
